// File: rtl/tx_frame_sched.sv
// Transmit frame scheduler: buffers Hamming codewords and serialises
// preamble, sync word, a fixed number of codewords and an idle gap,
// one bit per CLK_PER_BIT clocks, toward the FSK modulator.
module tx_frame_sched #(
   parameter int         CLK_PER_BIT     = 4,
   parameter logic [7:0] PREAMBLE        = 8'b10101010,
   parameter logic [7:0] SYNC_WORD       = 8'hD3,
   parameter int         WORDS_PER_FRAME = 4,
   parameter int         GAP_BITS        = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] cw_data,
   input  logic        cw_valid,
   output logic        cw_ready,
   output logic        bit_out,
   output logic        bit_valid,
   output logic        bit_tick,
   output logic        frame_active,
   output logic        underrun,
   output logic [7:0]  frame_cnt
);

   localparam int            CW        = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] CYC_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [15:0]   GAP_LAST  = 16'(GAP_BITS - 1);
   localparam logic [7:0]    WORD_LAST = 8'(WORDS_PER_FRAME - 1);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_SYNC, S_DATA, S_GAP} state_t;

   state_t        state;
   logic [CW-1:0] cyc_cnt;    // clock within the current bit period
   logic [15:0]   bit_idx;    // bit within the current segment (or word in DATA)
   logic [7:0]    word_idx;   // codeword slot within the frame
   logic [15:0]   shift_q;    // remaining bits of the current pattern/word, MSB next

   logic          buf_full;
   logic [15:0]   buf_data;

   logic          xfer;
   logic          period_end;
   logic          load;
   logic [15:0]   load_word;

   // Holding register is the only backpressure; held off while in reset.
   assign cw_ready   = ~buf_full & ~rst;
   assign xfer       = cw_valid & cw_ready;
   assign period_end = (cyc_cnt == CYC_LAST);

   // A word is pulled into the shifter at the end of the last SYNC bit and at
   // the end of bit 15 of every word except the last one of the frame.
   assign load = period_end &&
                 (((state == S_SYNC) && (bit_idx == 16'd7)) ||
                  ((state == S_DATA) && (bit_idx == 16'd15) && (word_idx != WORD_LAST)));

   // An empty buffer at a word boundary is filled with zeros; timing never stretches.
   assign load_word = buf_full ? buf_data : 16'h0000;

   // One-entry codeword buffer; a transfer on a load cycle refills it with the new word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_full <= 1'b0;
         buf_data <= 16'h0000;
      end else if (xfer) begin
         buf_full <= 1'b1;
         buf_data <= cw_data;
      end else if (load) begin
         buf_full <= 1'b0;
      end
   end

   // Frame FSM with registered serial outputs; each bit period ends on period_end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         cyc_cnt      <= '0;
         bit_idx      <= 16'd0;
         word_idx     <= 8'd0;
         shift_q      <= 16'h0000;
         bit_out      <= 1'b0;
         bit_valid    <= 1'b0;
         bit_tick     <= 1'b0;
         frame_active <= 1'b0;
         underrun     <= 1'b0;
         frame_cnt    <= 8'd0;
      end else begin
         bit_tick <= 1'b0;
         underrun <= 1'b0;
         case (state)
            S_IDLE: begin
               cyc_cnt      <= '0;
               bit_idx      <= 16'd0;
               word_idx     <= 8'd0;
               bit_out      <= 1'b0;
               bit_valid    <= 1'b0;
               frame_active <= 1'b0;
               if (enable && buf_full) begin
                  state        <= S_PRE;
                  bit_out      <= PREAMBLE[7];
                  shift_q      <= {PREAMBLE[6:0], 9'd0};
                  bit_valid    <= 1'b1;
                  frame_active <= 1'b1;
                  bit_tick     <= 1'b1;
               end
            end
            default: begin
               if (!period_end) begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end else begin
                  cyc_cnt  <= '0;
                  bit_tick <= 1'b1;
                  case (state)
                     S_PRE: begin
                        if (bit_idx == 16'd7) begin
                           state   <= S_SYNC;
                           bit_idx <= 16'd0;
                           bit_out <= SYNC_WORD[7];
                           shift_q <= {SYNC_WORD[6:0], 9'd0};
                        end else begin
                           bit_idx <= bit_idx + 16'd1;
                           bit_out <= shift_q[15];
                           shift_q <= {shift_q[14:0], 1'b0};
                        end
                     end
                     S_SYNC: begin
                        if (bit_idx == 16'd7) begin
                           state    <= S_DATA;
                           bit_idx  <= 16'd0;
                           word_idx <= 8'd0;
                           bit_out  <= load_word[15];
                           shift_q  <= {load_word[14:0], 1'b0};
                           underrun <= ~buf_full;
                        end else begin
                           bit_idx <= bit_idx + 16'd1;
                           bit_out <= shift_q[15];
                           shift_q <= {shift_q[14:0], 1'b0};
                        end
                     end
                     S_DATA: begin
                        if (bit_idx == 16'd15) begin
                           bit_idx <= 16'd0;
                           if (word_idx == WORD_LAST) begin
                              state        <= S_GAP;
                              bit_out      <= 1'b0;
                              bit_valid    <= 1'b0;
                              frame_active <= 1'b0;
                           end else begin
                              word_idx <= word_idx + 8'd1;
                              bit_out  <= load_word[15];
                              shift_q  <= {load_word[14:0], 1'b0};
                              underrun <= ~buf_full;
                           end
                        end else begin
                           bit_idx <= bit_idx + 16'd1;
                           bit_out <= shift_q[15];
                           shift_q <= {shift_q[14:0], 1'b0};
                        end
                     end
                     S_GAP: begin
                        bit_out <= 1'b0;
                        if (bit_idx == GAP_LAST) begin
                           // Frame done; IDLE costs one cycle before a new frame.
                           state     <= S_IDLE;
                           bit_idx   <= 16'd0;
                           bit_tick  <= 1'b0;
                           frame_cnt <= frame_cnt + 8'd1;
                        end else begin
                           bit_idx <= bit_idx + 16'd1;
                        end
                     end
                     default: begin
                        state <= S_IDLE;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed bench for tx_frame_sched: frame content, underrun fill, backpressure,
// enable handling, mid-frame reset and frame counter wrap.
module tb_tx_frame_sched;
   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] cw_data = 16'h0000;
   logic        cw_valid = 1'b0;
   logic        cw_ready, bit_out, bit_valid, bit_tick, frame_active, underrun;
   logic [7:0]  frame_cnt;

   // small-parameter instance for the wrap test
   logic        rst2 = 1'b1;
   logic        enable2 = 1'b0;
   logic [15:0] cw_data2 = 16'hC3C3;
   logic        cw_valid2 = 1'b0;
   logic        cw_ready2, bit_out2, bit_valid2, bit_tick2, frame_active2, underrun2;
   logic [7:0]  frame_cnt2;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [15:0] feed_q[$];

   tx_frame_sched dut (
      .clk(clk), .rst(rst), .enable(enable), .cw_data(cw_data), .cw_valid(cw_valid),
      .cw_ready(cw_ready), .bit_out(bit_out), .bit_valid(bit_valid), .bit_tick(bit_tick),
      .frame_active(frame_active), .underrun(underrun), .frame_cnt(frame_cnt)
   );

   tx_frame_sched #(.CLK_PER_BIT(2), .WORDS_PER_FRAME(1), .GAP_BITS(1)) dut2 (
      .clk(clk), .rst(rst2), .enable(enable2), .cw_data(cw_data2), .cw_valid(cw_valid2),
      .cw_ready(cw_ready2), .bit_out(bit_out2), .bit_valid(bit_valid2), .bit_tick(bit_tick2),
      .frame_active(frame_active2), .underrun(underrun2), .frame_cnt(frame_cnt2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present queued words with cw_valid held high until all are accepted.
   task automatic feed_all();
      int guard = 0;
      while (feed_q.size() > 0 && guard < 5000) begin
         @(negedge clk);
         guard++;
         cw_valid = 1'b1;
         cw_data  = feed_q[0];
         if (cw_ready) begin
            @(posedge clk);
            void'(feed_q.pop_front());
         end
      end
      @(negedge clk);
      cw_valid = 1'b0;
      chk("feed_done", 128'(feed_q.size()), 128'(0));
   endtask

   // Wait for the first PRE bit of a frame.
   task automatic wait_start(output int t0);
      bit ok = 1'b0;
      t0 = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (bit_tick && frame_active) begin
            ok = 1'b1;
            t0 = cyc;
         end
      end
      chk("frame_start", 128'(ok), 128'(1));
   endtask

   // Called on the first PRE cycle: collects the 80 frame bits, checks tick
   // spacing, bit stability and the 16 gap periods, counts underrun pulses.
   task automatic grab(output logic [79:0] bits, output int bad, output int urun);
      int   n = 1;
      int   since = 0;
      int   guard = 0;
      logic last;
      bits = '0;
      bits[79] = bit_out;
      last = bit_out;
      bad = 0;
      urun = 0;
      if (!bit_valid) bad++;
      while (n < 96 && guard < 2000) begin
         @(negedge clk);
         guard++;
         since++;
         if (underrun) urun++;
         if (bit_tick) begin
            if (since != CPB) bad++;
            since = 0;
            if (n < 80) begin
               bits[79-n] = bit_out;
               if (!bit_valid || !frame_active) bad++;
            end else if (bit_valid || bit_out || frame_active) bad++;
            last = bit_out;
            n++;
         end else if (bit_out != last) bad++;
      end
      if (n < 96) bad++;
      repeat (CPB) @(negedge clk);
      if (bit_tick || frame_active || bit_valid) bad++;
   endtask

   logic [79:0] bits_a, bits_b;
   int bad_a, bad_b, ur_a, ur_b, ta, tb, idle_bad;

   initial begin
      // T1: reset state
      repeat (3) @(negedge clk);
      chk("rst_outs", 128'({bit_out, bit_valid, bit_tick, frame_active, underrun, frame_cnt}), 128'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("rel_outs", 128'({bit_out, bit_valid, bit_tick, frame_active, underrun, frame_cnt}), 128'(0));
      chk("rel_ready", 128'(cw_ready), 128'(1));

      // T2: full frame
      enable = 1'b1;
      feed_q.push_back(16'hA5A5); feed_q.push_back(16'h1234);
      feed_q.push_back(16'hFFFF); feed_q.push_back(16'h0001);
      fork
         feed_all();
         begin wait_start(ta); grab(bits_a, bad_a, ur_a); end
      join
      chk("t2_bits", 128'(bits_a), 128'({8'hAA, 8'hD3, 16'hA5A5, 16'h1234, 16'hFFFF, 16'h0001}));
      chk("t2_timing", 128'(bad_a), 128'(0));
      chk("t2_underrun", 128'(ur_a), 128'(0));
      chk("t2_fcnt", 128'(frame_cnt), 128'(1));

      // T3: only two words, two zero fills
      feed_q.push_back(16'hBEEF); feed_q.push_back(16'h0F0F);
      fork
         feed_all();
         begin wait_start(ta); grab(bits_a, bad_a, ur_a); end
      join
      chk("t3_bits", 128'(bits_a), 128'({8'hAA, 8'hD3, 16'hBEEF, 16'h0F0F, 16'h0000, 16'h0000}));
      chk("t3_timing", 128'(bad_a), 128'(0));
      chk("t3_underrun", 128'(ur_a), 128'(2));
      chk("t3_fcnt", 128'(frame_cnt), 128'(2));

      // T4: eight words, cw_valid held, two back-to-back frames
      feed_q.push_back(16'h0123); feed_q.push_back(16'h4567);
      feed_q.push_back(16'h89AB); feed_q.push_back(16'hCDEF);
      feed_q.push_back(16'hFEDC); feed_q.push_back(16'hBA98);
      feed_q.push_back(16'h7654); feed_q.push_back(16'h3210);
      fork
         feed_all();
         begin
            wait_start(ta); grab(bits_a, bad_a, ur_a);
            wait_start(tb); grab(bits_b, bad_b, ur_b);
         end
      join
      chk("t4_bits_a", 128'(bits_a), 128'({8'hAA, 8'hD3, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF}));
      chk("t4_bits_b", 128'(bits_b), 128'({8'hAA, 8'hD3, 16'hFEDC, 16'hBA98, 16'h7654, 16'h3210}));
      chk("t4_timing", 128'(bad_a + bad_b), 128'(0));
      chk("t4_underrun", 128'(ur_a + ur_b), 128'(0));
      chk("t4_spacing", 128'(tb - ta), 128'(385));
      chk("t4_fcnt", 128'(frame_cnt), 128'(4));

      // T5: enable dropped during SYNC, fifth word waits in the buffer
      feed_q.push_back(16'h1357); feed_q.push_back(16'h2468);
      feed_q.push_back(16'h9ABC); feed_q.push_back(16'hDEF0);
      feed_q.push_back(16'h5A5A);
      fork
         feed_all();
         begin
            wait_start(ta);
            fork
               begin repeat (40) @(negedge clk); enable = 1'b0; end
               grab(bits_a, bad_a, ur_a);
            join
         end
      join
      chk("t5_bits", 128'(bits_a), 128'({8'hAA, 8'hD3, 16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0}));
      chk("t5_timing", 128'(bad_a), 128'(0));
      chk("t5_fcnt", 128'(frame_cnt), 128'(5));
      idle_bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (frame_active || bit_tick || bit_valid) idle_bad++;
      end
      chk("t5_stays_idle", 128'(idle_bad), 128'(0));
      chk("t5_buf_held", 128'(cw_ready), 128'(0));
      enable = 1'b1;
      @(negedge clk);
      chk("t5_restart", 128'({bit_tick, bit_valid, bit_out, frame_active}), 128'(4'b1111));
      grab(bits_a, bad_a, ur_a);
      enable = 1'b0;
      chk("t5b_bits", 128'(bits_a), 128'({8'hAA, 8'hD3, 16'h5A5A, 16'h0000, 16'h0000, 16'h0000}));
      chk("t5b_timing", 128'(bad_a), 128'(0));
      chk("t5b_underrun", 128'(ur_a), 128'(3));
      chk("t5b_fcnt", 128'(frame_cnt), 128'(6));

      // T1b: reset asserted mid-DATA
      enable = 1'b1;
      feed_q.push_back(16'hC0DE);
      fork
         feed_all();
         begin wait_start(ta); repeat (72) @(negedge clk); end
      join
      chk("mid_in_frame", 128'(frame_active), 128'(1));
      rst = 1'b1;
      #1;
      chk("mid_rst_outs", 128'({bit_out, bit_valid, bit_tick, frame_active, underrun, frame_cnt}), 128'(0));
      @(negedge clk);
      enable = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_rel", 128'({frame_active, bit_tick, frame_cnt, cw_ready}), 128'({1'b0, 1'b0, 8'd0, 1'b1}));

      // T6: 256 frames on the small instance, counter wrap and frame pitch
      begin
         int frames = 0;
         int guard = 0;
         int last = 0;
         int sep_bad = 0;
         int ur2 = 0;
         logic prev = 1'b0;
         @(negedge clk);
         rst2 = 1'b0;
         cw_valid2 = 1'b1;
         enable2 = 1'b1;
         while (frames < 256 && guard < 30000) begin
            @(negedge clk);
            guard++;
            if (underrun2) ur2++;
            if (frame_active2 && !prev) begin
               if (frames > 0 && (cyc - last) != 67) sep_bad++;
               if (frames == 255) begin
                  chk("t6_fcnt_255", 128'(frame_cnt2), 128'(255));
                  enable2 = 1'b0;
               end
               last = cyc;
               frames++;
            end
            prev = frame_active2;
         end
         chk("t6_frames", 128'(frames), 128'(256));
         chk("t6_spacing", 128'(sep_bad), 128'(0));
         for (int i = 0; i < 200 && frame_cnt2 == 8'd255; i++) @(negedge clk);
         chk("t6_wrap", 128'(frame_cnt2), 128'(0));
         chk("t6_underrun", 128'(ur2), 128'(0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
